sync_mod_counter: RTL

- Parametrised synchronous modulo-N up/down counter; successor to the team's ripple counter.
- All state bits update on one clock edge, so the count never passes through intermediate values.
- Adds a parallel load, a count enable, direction control, a terminal-count output for cascading, and a wrap pulse.
- Used as a building block for prescalers, timers and cascaded decade counters.

---
 rtl/sync_mod_counter_pkg.sv | 14 +
 rtl/sync_mod_counter_if.sv | 26 ++
 rtl/sync_dff_reg.sv | 37 +++
 rtl/sync_mod_counter.sv | 102 ++++++++++
 4 files changed

// File: rtl/sync_mod_counter_pkg.sv
// Shared definitions for the synchronous modulo-N counter.
//   DIR_UP / DIR_DN : encodings of the up_dn direction input.
//   clamp_load      : maps an out-of-range load value onto MODULUS-1.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int unsigned clamp_load(input int unsigned val,
                                               input int unsigned modulus);
        return (val < modulus) ? val : (modulus - 1);
    endfunction

endpackage

// File: rtl/sync_mod_counter_if.sv
// Control/status bundle of sync_mod_counter.
//   en, up_dn, load, load_val : controls, driven by the master.
//   q, tc, wrap               : count and status, driven by the counter (slave).
interface sync_mod_counter_if #(
    parameter int unsigned WIDTH = 4
);

    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, tc, wrap
    );

endinterface

// File: rtl/sync_dff_reg.sv
// Rising-edge register with synchronous active-high reset and a load enable.
//   clk   : clock
//   reset : synchronous reset to RESET_VAL; it takes priority over en
//   en    : when high, d is captured; otherwise the register holds
//   d     : next value
//   q     : registered value
module sync_dff_reg #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous modulo-MODULUS up/down counter with parallel load.
//   clk   : clock; all state changes on its rising edge
//   reset : synchronous active-high reset (q = RESET_VAL, wrap = 0)
//   bus   : slave side of sync_mod_counter_if
//     en, up_dn, load, load_val : count enable, direction (1 = up), load, load value
//     q    : registered count
//     tc   : combinational terminal count, meant to drive en of a cascaded stage
//     wrap : registered one-cycle pulse in the cycle after a wrap-around
// Priority on each edge: reset > load > en.
// Optional build macro SYNC_MOD_COUNTER_SATURATE_EN: hold at the limits instead of
// wrapping; wrap is then always 0 while tc still flags the limit.
module sync_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 16,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              reset,
    sync_mod_counter_if.slave bus
);

    // One extra bit so that MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0] ModExt = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] OneExt = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0] MaxExt = ModExt - OneExt;

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   nxt_ext;
    logic             q_en;

    assign q_ext = {1'b0, q_q};
    assign q_en  = bus.load | bus.en;

    always_comb begin
        nxt_ext = q_ext;
        wrap_d  = 1'b0;
        if (bus.load) begin
            nxt_ext = (WIDTH + 1)'(clamp_load(32'(bus.load_val), MODULUS));
        end else if (bus.en) begin
            if (q_ext >= ModExt) begin
                // Unreachable by construction; recover to a legal count.
                nxt_ext = '0;
            end else if (bus.up_dn == DIR_UP) begin
                if (q_ext == MaxExt) begin
`ifdef SYNC_MOD_COUNTER_SATURATE_EN
                    nxt_ext = MaxExt;
`else
                    nxt_ext = '0;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    nxt_ext = q_ext + OneExt;
                end
            end else begin
                if (q_ext == '0) begin
`ifdef SYNC_MOD_COUNTER_SATURATE_EN
                    nxt_ext = '0;
`else
                    nxt_ext = MaxExt;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    nxt_ext = q_ext - OneExt;
                end
            end
        end
        q_d = nxt_ext[WIDTH-1:0];
    end

    sync_dff_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (WIDTH'(RESET_VAL))
    ) u_q_reg (
        .clk   (clk),
        .reset (reset),
        .en    (q_en),
        .d     (q_d),
        .q     (q_q)
    );

    // Always enabled so the pulse self-clears after one cycle.
    sync_dff_reg #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_wrap_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (wrap_d),
        .q     (wrap_q)
    );

    assign bus.q    = q_q;
    assign bus.wrap = wrap_q;
    assign bus.tc   = bus.en & ~bus.load & ~reset &
                      ((bus.up_dn == DIR_DN) ? (q_ext == '0) : (q_ext == MaxExt));

endmodule
